alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised RV32/RV64 integer execute unit for the RISC-V core. It decodes `alu_op`/`f3`/`f7b5`/`f7b0` into the core's 4-bit ALU control code, computes the result and returns it over a valid/ready handshake. Single-cycle base ALU ops complete in one cycle; the optional M-extension adds a 2-cycle multiply and an iterative radix-2 divide. It sits between the ID/EX operand latch and the writeback mux, and stalls issue through `in_ready`.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64.
- `SHW`, default $clog2(XLEN): shift-amount width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept; combinational from state and `out_ready`.
- `alu_op`  in  2  00 add (load/store address), 01 sub (branch compare), 10 R-type, 11 I-type.
- `f3`  in  3  funct3.
- `f7b5`  in  1  funct7 bit 5 / imm bit 10.
- `f7b0`  in  1  funct7 bit 0; selects the M-extension when `alu_op`=10.
- `a`, `b`  in  XLEN  operands (`b` is the immediate for I-type).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  XLEN  registered result.
- `alu_con`  out  4  registered control code of the last accepted op, for trace.
- `err`  out  1  registered; the accepted op was unmapped.

## Operation
- **Control codes:**
  - 0000 and
  - 0001 or
  - 0010 add
  - 0011 sll
  - 0100 slt
  - 0101 sltu
  - 0110 sub
  - 0111 xor
  - 1000 srl
  - 1010 sra
  - 1100 mul family
  - 1101 div family
- **R-type (`alu_op`=10, `f7b0`=0):**
  - {f7b5,f3} = 0000 add, 1000 sub, 0111 and, 0110 or, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra.
  - Any other value sets `err`.
- **I-type (`alu_op`=11):**
  - Same mapping, but without sub.
  - `f7b5` is ignored except when f3=101 (srli/srai).
- **M-extension (`alu_op`=10, `f7b0`=1):**
  - f3 000 mul, 001 mulh, 010 mulhsu, 011 mulhu: code 1100.
  - f3 100 div, 101 divu, 110 rem, 111 remu: code 1101.
- **Arithmetic:**
  - Add and sub wrap modulo 2^XLEN.
  - Shifts use `b[SHW-1:0]`.
  - slt and sltu return 0 or 1, zero-extended.
  - mulh variants return the upper XLEN bits of the 2·XLEN product.
- **States:**
  - IDLE: `in_ready`=1.
    - If the accepted op is base, immediate, erroneous or a div fast-path case, go to DONE.
    - If it is a mul, go to MUL.
    - If it is a normal div, go to DIV with count=XLEN−1.
  - MUL: the product is registered, then go to DONE.
  - DIV: one restoring quotient bit per cycle. When count=0, go to DONE; otherwise decrement count.
  - DONE: `out_valid`=1.
    - If `out_ready`=1, go to IDLE.
    - If `out_ready`=1 and `in_valid`=1, also accept the new op in the same cycle (`in_ready`=`out_ready` in DONE).
- **Div fast path:**
  - Divide by zero: quotient all-ones, remainder = `a`.
  - Signed overflow (`a`=100…0, `b`=all-ones): quotient = `a`, remainder 0.
- **Signed div/rem:**
  - Operands are converted to magnitudes.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of `a`.
- **Errors:** `err`=1 forces `result`=0.

## Timing
- **Reset** (on the `clk` edge while `rst`=1):
  - state IDLE
  - `out_valid`=0
  - `result`=0
  - `alu_con`=0000
  - `err`=0
  - `in_ready`=1 from the first cycle after reset
- **Reset mid-operation:** aborts MUL or DIV. No `out_valid` is produced for the aborted op.
- **Latency**, from the accept edge to the first cycle `out_valid`=1:
  - base, immediate, error or div fast path: 1 cycle
  - mul: 2 cycles
  - div: XLEN+1 cycles
- **Output stability:** `result`, `alu_con` and `err` stay stable while `out_valid`=1 and `out_ready`=0.
- **Throughput:** back-to-back single-cycle ops run at 1 per cycle when `out_ready` is held at 1.
- **Busy cycles:** in MUL and DIV, `in_ready`=0 and `in_valid` is ignored.

## Configuration
- `RV_M_EXT_EN` defined:
  - The MUL and DIV states, the multiplier and the divider are compiled in.
- `RV_M_EXT_EN` undefined:
  - No multiplier, divider or MUL/DIV states exist.
  - Any `alu_op`=10 op with `f7b0`=1 sets `err`=1 and `result`=0 with 1-cycle latency.
  - The `f7b0` port remains present.

## Test plan
- Reset with `rst`=1 for 2 cycles → `out_valid`=0, `result`=0, `err`=0, `in_ready`=1.
- R-type sub, a=5, b=7 → `result`=0xFFFFFFFE, `alu_con`=0110, `out_valid` 1 cycle after accept. I-type srai, a=0x80000000, b=0x404 → `result`=0xF8000000.
- Unmapped R-type {f7b5,f3}=1001 → `err`=1, `result`=0. I-type f3=000 with `f7b5`=1 → addi (`alu_con`=0010), `err`=0.
- Divs (with `RV_M_EXT_EN`):
  - a=−7, b=2 → quotient −3, rem −1, `out_valid` at cycle XLEN+1.
  - Div by 0 → quotient 0xFFFFFFFF at cycle 1.
  - 0x80000000 / −1 → 0x80000000.
- mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE, latency 2. Without `RV_M_EXT_EN` the same op gives `err`=1.
- Handshakes and reset:
  - Hold `out_ready`=0 for 3 cycles → result is held and `in_ready`=0.
  - Then `out_ready`=`in_valid`=1 → the next op is accepted in the same cycle.
  - Assert `rst` at DIV cycle 10 → IDLE, no `out_valid`.

Source files
------------

// File: rtl/alu_exec_unit.sv
// RV32/RV64 integer execute unit: decodes ALU control, computes, returns the result over valid/ready.
// Define RV_M_EXT_EN to compile in the 2-cycle multiplier and the radix-2 restoring divider.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      f3,
  input  logic            f7b5,
  input  logic            f7b0,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_con,
  output logic            err
);

  localparam logic [3:0] ConAnd  = 4'b0000;
  localparam logic [3:0] ConOr   = 4'b0001;
  localparam logic [3:0] ConAdd  = 4'b0010;
  localparam logic [3:0] ConSll  = 4'b0011;
  localparam logic [3:0] ConSlt  = 4'b0100;
  localparam logic [3:0] ConSltu = 4'b0101;
  localparam logic [3:0] ConSub  = 4'b0110;
  localparam logic [3:0] ConXor  = 4'b0111;
  localparam logic [3:0] ConSrl  = 4'b1000;
  localparam logic [3:0] ConSra  = 4'b1010;

`ifdef RV_M_EXT_EN
  localparam logic [3:0] ConMul  = 4'b1100;
  localparam logic [3:0] ConDiv  = 4'b1101;
  typedef enum logic [1:0] {StIdle, StDone, StMul, StDiv} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDone} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_res;
  logic [3:0]      alu_con_q, alu_con_d, dec_con;
  logic            err_q, err_d, dec_err;
  logic [SHW-1:0]  shamt;

  assign shamt = b[SHW-1:0];

`ifdef RV_M_EXT_EN
  logic            dec_m;
  // op_a holds the mul multiplicand or the shifting dividend/quotient; op_b the multiplier/divisor.
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d, rem_q, rem_d;
  logic [1:0]      mf3_q, mf3_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, is_rem_q, is_rem_d;
  logic            sa_ext, sb_ext, div_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [2*XLEN-1:0] mul_x, mul_y, mul_p;
  logic [XLEN:0]   rem_sh, rem_df;
  logic [XLEN-1:0] mul_res, quo_nx, rem_nx, div_res, div_fast;

  always_comb begin
    sa_ext  = (mf3_q != 2'b11) & op_a_q[XLEN-1];
    sb_ext  = (mf3_q == 2'b01) & op_b_q[XLEN-1];
    mul_x   = {{XLEN{sa_ext}}, op_a_q};
    mul_y   = {{XLEN{sb_ext}}, op_b_q};
    mul_p   = mul_x * mul_y;
    mul_res = (mf3_q == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

    rem_sh = {rem_q, op_a_q[XLEN-1]};
    rem_df = rem_sh - {1'b0, op_b_q};
    if (rem_df[XLEN]) begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {op_a_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = rem_df[XLEN-1:0];
      quo_nx = {op_a_q[XLEN-2:0], 1'b1};
    end
    if (is_rem_q) div_res = rneg_q ? -rem_nx : rem_nx;
    else          div_res = qneg_q ? -quo_nx : quo_nx;

    div_sgn  = ~f3[0];
    a_neg    = div_sgn & a[XLEN-1];
    b_neg    = div_sgn & b[XLEN-1];
    div_zero = (b == '0);
    div_ovf  = div_sgn & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    if (div_zero) div_fast = f3[1] ? a : '1;
    else          div_fast = f3[1] ? '0 : a;
  end
`endif

  // Unmapped ops trace as control code 0000.
  always_comb begin
    dec_con = ConAdd;
    dec_err = 1'b0;
`ifdef RV_M_EXT_EN
    dec_m   = 1'b0;
`endif
    unique case (alu_op)
      2'b00: dec_con = ConAdd;
      2'b01: dec_con = ConSub;
      2'b10: begin
        if (f7b0) begin
`ifdef RV_M_EXT_EN
          dec_m   = 1'b1;
          dec_con = f3[2] ? ConDiv : ConMul;
`else
          dec_err = 1'b1;
`endif
        end else begin
          unique case ({f7b5, f3})
            4'b0000: dec_con = ConAdd;
            4'b1000: dec_con = ConSub;
            4'b0111: dec_con = ConAnd;
            4'b0110: dec_con = ConOr;
            4'b0001: dec_con = ConSll;
            4'b0010: dec_con = ConSlt;
            4'b0011: dec_con = ConSltu;
            4'b0100: dec_con = ConXor;
            4'b0101: dec_con = ConSrl;
            4'b1101: dec_con = ConSra;
            default: dec_err = 1'b1;
          endcase
        end
      end
      default: begin
        unique case (f3)
          3'b000:  dec_con = ConAdd;
          3'b001:  dec_con = ConSll;
          3'b010:  dec_con = ConSlt;
          3'b011:  dec_con = ConSltu;
          3'b100:  dec_con = ConXor;
          3'b101:  dec_con = f7b5 ? ConSra : ConSrl;
          3'b110:  dec_con = ConOr;
          default: dec_con = ConAnd;
        endcase
      end
    endcase
    if (dec_err) dec_con = 4'b0000;
  end

  always_comb begin
    case (dec_con)
      ConAnd:  alu_res = a & b;
      ConOr:   alu_res = a | b;
      ConAdd:  alu_res = a + b;
      ConSll:  alu_res = a << shamt;
      ConSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ConSltu: alu_res = {{(XLEN-1){1'b0}}, a < b};
      ConSub:  alu_res = a - b;
      ConXor:  alu_res = a ^ b;
      ConSrl:  alu_res = a >> shamt;
      ConSra:  alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign alu_con   = alu_con_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    alu_con_d = alu_con_q;
    err_d     = err_q;
`ifdef RV_M_EXT_EN
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rem_d    = rem_q;
    mf3_d    = mf3_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
`endif
    case (state_q)
      StDone: if (out_ready) state_d = StIdle;
`ifdef RV_M_EXT_EN
      StMul: begin
        result_d = mul_res;
        state_d  = StDone;
      end
      StDiv: begin
        op_a_d = quo_nx;
        rem_d  = rem_nx;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          result_d = div_res;
          state_d  = StDone;
        end
      end
`endif
      default: ;
    endcase

    if (in_valid && in_ready) begin
      alu_con_d = dec_con;
      err_d     = dec_err;
      result_d  = dec_err ? '0 : alu_res;
      state_d   = StDone;
`ifdef RV_M_EXT_EN
      if (dec_m) begin
        if (!f3[2]) begin
          op_a_d  = a;
          op_b_d  = b;
          mf3_d   = f3[1:0];
          state_d = StMul;
        end else if (div_zero || div_ovf) begin
          result_d = div_fast;
        end else begin
          op_a_d   = a_neg ? -a : a;
          op_b_d   = b_neg ? -b : b;
          rem_d    = '0;
          cnt_d    = SHW'(XLEN - 1);
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          is_rem_d = f3[1];
          state_d  = StDiv;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      result_q  <= '0;
      alu_con_q <= 4'b0000;
      err_q     <= 1'b0;
`ifdef RV_M_EXT_EN
      op_a_q   <= '0;
      op_b_q   <= '0;
      rem_q    <= '0;
      mf3_q    <= 2'b00;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      alu_con_q <= alu_con_d;
      err_q     <= err_d;
`ifdef RV_M_EXT_EN
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rem_q    <= rem_d;
      mf3_q    <= mf3_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_rem_q <= is_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake/reset sequences,
// and randomized ops against a behavioural model. Follows RV_M_EXT_EN like the design.
module tb_alu_exec_unit;
  localparam int XLEN = 32;
`ifdef RV_M_EXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = '0;
  logic [2:0]      f3 = '0;
  logic            f7b5 = 1'b0;
  logic            f7b0 = 1'b0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic [3:0]      alu_con;
  logic            err;

  int n_vec = 0;
  int n_bad = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .f3(f3), .f7b5(f7b5), .f7b0(f7b0), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .alu_con(alu_con), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f;
    logic        f75;
    logic        f70;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] r;
    logic [3:0]  c;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: names the operation, then evaluates it with plain arithmetic.
  task automatic model(input logic [1:0] op, input logic [2:0] f, input logic f75, f70,
                       input logic [31:0] va, vb, output logic [31:0] r, output logic [3:0] c,
                       output logic e, output int lat);
    logic signed [31:0] sa, sb, sq, sr;
    logic [63:0] p;
    logic [31:0] q, rm;
    string nm;
    sa = va; sb = vb; r = '0; c = 4'd0; e = 1'b0; lat = 1; nm = "err";
    p = '0; q = '0; rm = '0;
    case (op)
      2'd0: nm = "add";
      2'd1: nm = "sub";
      2'd2: begin
        if (f70) nm = MEXT ? (f[2] ? "div" : "mul") : "err";
        else case ({f75, f})
          4'b0000: nm = "add";  4'b1000: nm = "sub";  4'b0111: nm = "and";
          4'b0110: nm = "or";   4'b0001: nm = "sll";  4'b0010: nm = "slt";
          4'b0011: nm = "sltu"; 4'b0100: nm = "xor";  4'b0101: nm = "srl";
          4'b1101: nm = "sra";  default: nm = "err";
        endcase
      end
      default: case (f)
        3'd0: nm = "add"; 3'd1: nm = "sll"; 3'd2: nm = "slt"; 3'd3: nm = "sltu";
        3'd4: nm = "xor"; 3'd5: nm = f75 ? "sra" : "srl"; 3'd6: nm = "or"; default: nm = "and";
      endcase
    endcase
    case (nm)
      "add":  begin r = va + vb; c = 4'd2; end
      "sub":  begin r = va - vb; c = 4'd6; end
      "and":  begin r = va & vb; c = 4'd0; end
      "or":   begin r = va | vb; c = 4'd1; end
      "xor":  begin r = va ^ vb; c = 4'd7; end
      "sll":  begin r = va << (vb % 32); c = 4'd3; end
      "srl":  begin r = va >> (vb % 32); c = 4'd8; end
      "sra":  begin r = sa >>> (vb % 32); c = 4'd10; end
      "slt":  begin r = (sa < sb) ? 32'd1 : 32'd0; c = 4'd4; end
      "sltu": begin r = (va < vb) ? 32'd1 : 32'd0; c = 4'd5; end
      "mul": begin
        c = 4'd12; lat = 2;
        case (f[1:0])
          2'd0: p = longint'(sa) * longint'(sb);
          2'd1: p = longint'(sa) * longint'(sb);
          2'd2: p = longint'(sa) * longint'({32'd0, vb});
          default: p = {32'd0, va} * {32'd0, vb};
        endcase
        r = (f[1:0] == 2'd0) ? p[31:0] : p[63:32];
      end
      "div": begin
        c = 4'd13;
        if (vb == 32'd0) begin
          q = 32'hFFFF_FFFF; rm = va;
        end else if (!f[0] && va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) begin
          q = va; rm = 32'd0;
        end else begin
          lat = XLEN + 1;
          if (!f[0]) begin sq = sa / sb; sr = sa % sb; q = sq; rm = sr; end
          else begin q = va / vb; rm = va % vb; end
        end
        r = f[1] ? rm : q;
      end
      default: begin e = 1'b1; r = '0; c = 4'd0; end
    endcase
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f,
                        input logic f75, f70, input logic [31:0] va, vb,
                        input logic [31:0] er, input logic [3:0] ec, input logic ee,
                        input int el);
    int guard;
    int lat;
    alu_op = op; f3 = f; f7b5 = f75; f7b0 = f70; a = va; b = vb;
    in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    check({name, ".in_ready"}, 64'(guard < 200), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({name, ".latency"}, 64'(lat), 64'(el));
    check({name, ".result"}, 64'(result), 64'(er));
    check({name, ".alu_con"}, 64'(alu_con), 64'(ec));
    check({name, ".err"}, 64'(err), 64'(ee));
  endtask

  task automatic add_vec(input string n, input logic [1:0] op, input logic [2:0] f,
                         input logic f75, f70, input logic [31:0] va, vb, r,
                         input logic [3:0] c, input logic e, input int lat);
    vec_t v;
    v = '{name: n, op: op, f: f, f75: f75, f70: f70, va: va, vb: vb, r: r, c: c, e: e, lat: lat};
    if (!MEXT && op == 2'd2 && f70) begin
      v.r = '0; v.c = 4'd0; v.e = 1'b1; v.lat = 1;
    end
    tbl.push_back(v);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [2:0]  rf;
    logic        r75, r70, ee;
    logic [31:0] ra, rb, er;
    logic [3:0]  ec;
    int          el, viol;

    add_vec("sub",    2'd2, 3'd0, 1, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 0, 1);
    add_vec("srai",   2'd3, 3'd5, 1, 0, 32'h8000_0000, 32'h404, 32'hF800_0000, 4'b1010, 0, 1);
    add_vec("unmap",  2'd2, 3'd1, 1, 0, 32'd3, 32'd4, 32'd0, 4'b0000, 1, 1);
    add_vec("addi_f", 2'd3, 3'd0, 1, 0, 32'd10, 32'd3, 32'd13, 4'b0010, 0, 1);
    add_vec("ld_add", 2'd0, 3'd7, 1, 1, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0010, 0, 1);
    add_vec("br_sub", 2'd1, 3'd0, 0, 0, 32'd3, 32'd3, 32'd0, 4'b0110, 0, 1);
    add_vec("slt",    2'd2, 3'd2, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0100, 0, 1);
    add_vec("sltu",   2'd2, 3'd3, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0101, 0, 1);
    add_vec("sll",    2'd2, 3'd1, 0, 0, 32'd1, 32'h25, 32'h20, 4'b0011, 0, 1);
    add_vec("srl",    2'd2, 3'd5, 0, 0, 32'h8000_0000, 32'd31, 32'd1, 4'b1000, 0, 1);
    add_vec("and",    2'd2, 3'd7, 0, 0, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000, 0, 1);
    add_vec("xor",    2'd2, 3'd4, 0, 0, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'b0111, 0, 1);
    add_vec("div",    2'd2, 3'd4, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'b1101, 0, XLEN+1);
    add_vec("rem",    2'd2, 3'd6, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b1101, 0, XLEN+1);
    add_vec("divu",   2'd2, 3'd5, 0, 1, 32'd100, 32'd7, 32'd14, 4'b1101, 0, XLEN+1);
    add_vec("div0",   2'd2, 3'd4, 0, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b1101, 0, 1);
    add_vec("rem0",   2'd2, 3'd6, 0, 1, 32'd5, 32'd0, 32'd5, 4'b1101, 0, 1);
    add_vec("divovf", 2'd2, 3'd4, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1101, 0, 1);
    add_vec("mulhu",  2'd2, 3'd3, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1100, 0, 2);
    add_vec("mul",    2'd2, 3'd0, 0, 1, 32'd7, 32'd6, 32'd42, 4'b1100, 0, 2);
    add_vec("mulh",   2'd2, 3'd1, 0, 1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 4'b1100, 0, 2);

    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.alu_con", 64'(alu_con), 64'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i])
      run_op(tbl[i].name, tbl[i].op, tbl[i].f, tbl[i].f75, tbl[i].f70, tbl[i].va, tbl[i].vb,
             tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].lat);

    // Stall with out_ready low, then accept a new op in the releasing cycle.
    idle();
    out_ready = 1'b0;
    alu_op = 2'd0; f3 = 3'd0; f7b5 = 1'b0; f7b0 = 1'b0; a = 32'd11; b = 32'd22;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall.out_valid0", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall.result", 64'(result), 64'd33);
      check("stall.in_ready", 64'(in_ready), 64'd0);
      check("stall.out_valid", 64'(out_valid), 64'd1);
    end
    alu_op = 2'd3; f3 = 3'd4; a = 32'd5; b = 32'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("release.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release.out_valid", 64'(out_valid), 64'd1);
    check("release.result", 64'(result), 64'd6);
    check("release.alu_con", 64'(alu_con), 64'd7);

    // Back-to-back single-cycle ops at one per cycle.
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_op = 2'd0; a = 32'(i * 100); b = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      check("b2b.result", 64'(result), 64'(i * 100 + 1));
      check("b2b.out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;

    // Reset in the middle of a long op aborts it.
    idle();
    out_ready = 1'b0;
    alu_op = 2'd2; f3 = 3'd4; f7b5 = 1'b0; f7b0 = 1'b1; a = 32'd100; b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy.in_ready", 64'(in_ready), 64'd0);
    check("busy.out_valid", 64'(out_valid), 64'(!MEXT));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.result", 64'(result), 64'd0);
    viol = 0;
    repeat (XLEN + 5) begin
      @(posedge clk); #1;
      if (out_valid) viol++;
    end
    check("abort.no_valid", 64'(viol), 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = 3'($urandom_range(0, 7));
      r75 = 1'($urandom_range(0, 1));
      r70 = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      model(rop, rf, r75, r70, ra, rb, er, ec, ee, el);
      run_op("rand", rop, rf, r75, r70, ra, rb, er, ec, ee, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
